// File: rtl/axi_stream_read_responder.sv
// axi_stream_read_responder: serves queued AXI4 AR requests with arlen+1 beats of stream data each.
module axi_stream_read_responder #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 16,
  parameter int AR_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [63:0]           s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [31:0]           bursts_done,
  output logic                  size_err
);
  localparam int AW = $clog2(AR_DEPTH);
  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));
  typedef enum logic {IDLE, BURST} state_t;
  state_t r_state, w_next;
  logic [ID_WIDTH-1:0] r_fifo_id [AR_DEPTH];
  logic [7:0]          r_fifo_len [AR_DEPTH];
  logic                r_fifo_bad [AR_DEPTH];
  logic [AW:0]         r_wptr, r_rptr;
  logic [ID_WIDTH-1:0] r_cur_id;
  logic [7:0]          r_cur_len, r_beat_cnt;
  logic                r_cur_bad;
  logic                w_full, w_empty, w_push, w_pop, w_busy, w_hs, w_last, w_unused;
  assign w_unused = ^s_axi_araddr;
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = r_wptr == r_rptr;
  assign s_axi_arready = !w_full && !reset;
  assign w_push = s_axi_arvalid && s_axi_arready;
  assign w_pop  = r_state == IDLE && !w_empty;
  assign w_busy = r_state == BURST && !reset;
  assign s_axi_rvalid  = w_busy && s_axis_tvalid;
  assign s_axis_tready = w_busy && s_axi_rready;
  assign s_axi_rdata   = s_axis_tdata;
  assign s_axi_rid     = r_cur_id;
  assign s_axi_rresp   = r_cur_bad ? 2'd2 : 2'd0;
  assign s_axi_rlast   = w_busy && r_beat_cnt == r_cur_len;
  assign w_hs   = s_axi_rvalid && s_axi_rready;
  assign w_last = w_hs && s_axi_rlast;
  always_ff @(posedge clock)
    if (w_push) begin
      r_fifo_id[r_wptr[AW-1:0]]  <= s_axi_arid;
      r_fifo_len[r_wptr[AW-1:0]] <= s_axi_arlen;
      r_fifo_bad[r_wptr[AW-1:0]] <= s_axi_arsize != SIZE;
    end
  always_ff @(posedge clock)
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cur_id    <= '0;
      r_cur_len   <= '0;
      r_cur_bad   <= 1'b0;
      r_beat_cnt  <= '0;
      bursts_done <= '0;
      size_err    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr     <= r_rptr + 1'b1;
        r_cur_id   <= r_fifo_id[r_rptr[AW-1:0]];
        r_cur_len  <= r_fifo_len[r_rptr[AW-1:0]];
        r_cur_bad  <= r_fifo_bad[r_rptr[AW-1:0]];
        r_beat_cnt <= '0;
      end else if (w_hs) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (w_last) bursts_done <= bursts_done + 1'b1;
      if (w_push && s_axi_arsize != SIZE) size_err <= 1'b1;
    end
  always_ff @(posedge clock) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_empty ? IDLE : BURST;
    else w_next = w_last ? IDLE : BURST;
  end
endmodule

// File: tb/tb_axi_stream_read_responder.sv
// tb_axi_stream_read_responder: directed checks of AR queueing, beat sequencing, stalls and reset.
module tb_axi_stream_read_responder;
  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  arid;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic         arvalid, arready;
  logic [15:0]  rid;
  logic [511:0] rdata, tdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready, tvalid, tready, size_err;
  logic [31:0]  bursts_done;
  int tests = 0;
  int fails = 0;
  axi_stream_read_responder dut (
    .clock(clk), .reset(reset),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .bursts_done(bursts_done), .size_err(size_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    reset = 1; arid = 0; araddr = 64'h1000; arlen = 0; arsize = 3'd6; arvalid = 0;
    rready = 0; tdata = '0; tvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_tready", tready, 0);
    reset = 0;
    #1;
    chk("post_rst_arready", arready, 1);
    chk("post_rst_rlast", rlast, 0);
    chk("post_rst_rid", rid, 0);
    chk("post_rst_rresp", rresp, 0);
    chk("post_rst_bursts", bursts_done, 0);
    chk("post_rst_size_err", size_err, 0);
    // single 4-beat burst
    cyc(); arvalid = 1; arid = 16'h5; arlen = 3; tvalid = 1; tdata = 512'd100; rready = 1; #1;
    chk("t1_rvalid_push", rvalid, 0);
    cyc(); arvalid = 0; #1;
    chk("t1_rvalid_idle", rvalid, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); tdata = 512'(100 + i); #1;
      chk("t1_rvalid", rvalid, 1);
      chk("t1_rid", rid, 16'h5);
      chk("t1_rdata", rdata, 512'(100 + i));
      chk("t1_rlast", rlast, i == 3);
      chk("t1_tready", tready, 1);
    end
    cyc(); #1;
    chk("t1_end_rvalid", rvalid, 0);
    chk("t1_bursts", bursts_done, 1);
    // back-to-back arlen=0 and arlen=1
    cyc(); arvalid = 1; arid = 16'h1; arlen = 0; tvalid = 0; #1;
    cyc(); arid = 16'h2; arlen = 1; #1;
    cyc(); arvalid = 0; tvalid = 1; tdata = 512'hA0; #1;
    chk("t2_b0_rvalid", rvalid, 1);
    chk("t2_b0_rid", rid, 16'h1);
    chk("t2_b0_rlast", rlast, 1);
    chk("t2_b0_rdata", rdata, 512'hA0);
    cyc(); tdata = 512'hA1; #1;
    chk("t2_gap_rvalid", rvalid, 0);
    chk("t2_gap_tready", tready, 0);
    cyc(); #1;
    chk("t2_b1_rid", rid, 16'h2);
    chk("t2_b1_rlast", rlast, 0);
    chk("t2_b1_rdata", rdata, 512'hA1);
    cyc(); tdata = 512'hA2; #1;
    chk("t2_b2_rlast", rlast, 1);
    chk("t2_b2_rdata", rdata, 512'hA2);
    cyc(); #1;
    chk("t2_end_rvalid", rvalid, 0);
    chk("t2_bursts", bursts_done, 3);
    // rready stalls mid-burst
    cyc(); arvalid = 1; arid = 16'h7; arlen = 2; tdata = 512'hB0; #1;
    cyc(); arvalid = 0; #1;
    chk("t3_idle_rvalid", rvalid, 0);
    cyc(); #1;
    chk("t3_b0_rdata", rdata, 512'hB0);
    chk("t3_b0_tready", tready, 1);
    cyc(); tdata = 512'hB1; rready = 0; #1;
    chk("t3_stall_rvalid", rvalid, 1);
    chk("t3_stall_tready", tready, 0);
    chk("t3_stall_rid", rid, 16'h7);
    chk("t3_stall_rlast", rlast, 0);
    cyc(); #1;
    chk("t3_stall2_rdata", rdata, 512'hB1);
    chk("t3_stall2_rlast", rlast, 0);
    cyc(); rready = 1; #1;
    chk("t3_resume_rdata", rdata, 512'hB1);
    chk("t3_resume_tready", tready, 1);
    chk("t3_resume_rlast", rlast, 0);
    cyc(); tdata = 512'hB2; #1;
    chk("t3_last_rlast", rlast, 1);
    chk("t3_last_rdata", rdata, 512'hB2);
    cyc(); #1;
    chk("t3_bursts", bursts_done, 4);
    // FIFO full while the FSM is stuck in a burst with no stream data
    cyc(); arvalid = 1; arid = 16'h10; arlen = 0; tvalid = 0; #1;
    cyc(); arvalid = 0; #1;
    for (int i = 0; i < 4; i++) begin
      cyc(); arvalid = 1; arid = 16'(16'h11 + i); #1;
      chk("t4_arready_fill", arready, 1);
    end
    cyc(); arid = 16'h15; #1;
    chk("t4_full_arready", arready, 0);
    chk("t4_full_rvalid", rvalid, 0);
    cyc(); tvalid = 1; tdata = 512'hC0; #1;
    chk("t4_b_rid", rid, 16'h10);
    chk("t4_b_rlast", rlast, 1);
    chk("t4_b_arready", arready, 0);
    cyc(); tvalid = 0; #1;
    chk("t4_popcyc_arready", arready, 0);
    cyc(); #1;
    chk("t4_rise_arready", arready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); arvalid = 0; tvalid = 1; tdata = 512'(32'hC1 + i); #1;
      chk("t4_drain_rvalid", rvalid, 1);
      chk("t4_drain_rid", rid, 16'(16'h11 + i));
      chk("t4_drain_rlast", rlast, 1);
      chk("t4_drain_rdata", rdata, 512'(32'hC1 + i));
      cyc(); tvalid = 0; #1;
      chk("t4_drain_gap", rvalid, 0);
    end
    chk("t4_bursts", bursts_done, 10);
    // bad arsize
    cyc(); arvalid = 1; arid = 16'h21; arlen = 1; arsize = 3'd3; tvalid = 1; tdata = 512'hD0; #1;
    cyc(); arvalid = 0; arsize = 3'd6; #1;
    chk("t5_size_err_set", size_err, 1);
    chk("t5_idle_rvalid", rvalid, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); tdata = 512'(32'hD0 + i); #1;
      chk("t5_rresp", rresp, 2);
      chk("t5_rlast", rlast, i == 1);
      chk("t5_rid", rid, 16'h21);
    end
    cyc(); #1;
    chk("t5_end_rvalid", rvalid, 0);
    chk("t5_size_err_sticky", size_err, 1);
    chk("t5_rresp_hold", rresp, 2);
    chk("t5_bursts", bursts_done, 11);
    // reset mid-burst with a second request queued
    cyc(); arvalid = 1; arid = 16'h30; arlen = 7; tdata = 512'hE0; #1;
    cyc(); arid = 16'h31; arlen = 0; #1;
    chk("t6_idle_rvalid", rvalid, 0);
    cyc(); arvalid = 0; #1;
    chk("t6_b0_rdata", rdata, 512'hE0);
    chk("t6_b0_rlast", rlast, 0);
    cyc(); tdata = 512'hE1; #1;
    chk("t6_b1_rvalid", rvalid, 1);
    cyc(); tdata = 512'hE2; reset = 1; #1;
    chk("t6_rst_rvalid", rvalid, 0);
    chk("t6_rst_tready", tready, 0);
    chk("t6_rst_arready", arready, 0);
    chk("t6_rst_rlast", rlast, 0);
    cyc(); reset = 0; #1;
    chk("t6_post_rvalid", rvalid, 0);
    chk("t6_post_bursts", bursts_done, 0);
    chk("t6_post_size_err", size_err, 0);
    chk("t6_post_rid", rid, 0);
    chk("t6_post_rresp", rresp, 0);
    chk("t6_post_arready", arready, 1);
    cyc(); #1;
    chk("t6_fifo_empty", rvalid, 0);
    cyc(); arvalid = 1; arid = 16'h40; arlen = 0; #1;
    cyc(); arvalid = 0; #1;
    chk("t6_new_idle", rvalid, 0);
    cyc(); #1;
    chk("t6_new_rvalid", rvalid, 1);
    chk("t6_new_rid", rid, 16'h40);
    chk("t6_new_rlast", rlast, 1);
    chk("t6_new_rdata", rdata, 512'hE2);
    cyc(); #1;
    chk("t6_new_bursts", bursts_done, 1);
    chk("t6_new_end_rvalid", rvalid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
